// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_flags slice.
package sync_fifo_pkg;

  localparam int unsigned AE_THRESH_DEFAULT = 2;
  localparam int unsigned AF_MARGIN_DEFAULT = 2;

  // Encoding is {write_accepted, read_accepted} so the pair casts directly.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy/threshold flags and rejected-request pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - AF_MARGIN_DEFAULT,
  parameter int unsigned AE_THRESH = AE_THRESH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   wr_error_o,
  output logic                   rd_error_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_err_q, rd_err_q;
  logic             wr_ok, rd_ok;
  fifo_op_e         op;
  logic [WIDTH-1:0] mem_rdata;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // when paired with an accepted read; the reverse is not true when empty.
  always_comb begin
    rd_ok   = rd_en_i && !empty_o;
    wr_ok   = wr_en_i && (!full_o || rd_ok);
    op      = fifo_op_e'({wr_ok, rd_ok});
    count_d = count_q;
    case (op)
      OP_WRITE: count_d = count_q + CW'(1);
      OP_READ:  count_d = count_q - CW'(1);
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_d;
      wr_err_q <= wr_en_i && !wr_ok;
      rd_err_q <= rd_en_i && !rd_ok;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata_o = empty_o ? '0 : mem_rdata;
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rdata_q <= '0;
    else if (rd_ok) rdata_q <= mem_rdata;
  end

  assign rdata_o = rdata_q;
`endif

  assign count_o        = count_q;
  assign full_o         = (count_q == CW'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags (WIDTH=8, DEPTH=16, default thresholds).
module tb_sync_fifo_flags;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full, empty, afull, aempty;
  logic [4:0]       count;
  logic             wr_err, rd_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  string       phase    = "reset";

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] last_rd;
  logic             exp_wr_err, exp_rd_err;

  sync_fifo_flags #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wr_en_i        (wr_en),
    .wdata_i        (wdata),
    .rd_en_i        (rd_en),
    .rdata_o        (rdata),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (afull),
    .almost_empty_o (aempty),
    .count_o        (count),
    .wr_error_o     (wr_err),
    .rd_error_o     (rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int unsigned n;
    logic [WIDTH-1:0] exp_rd;
    n = exp_q.size();
`ifdef SYNC_FIFO_FWFT_EN
    exp_rd = (n > 0) ? exp_q[0] : '0;
`else
    exp_rd = last_rd;
`endif
    check("count",  32'(count),  32'(n));
    check("full",   32'(full),   32'(n == DEPTH));
    check("empty",  32'(empty),  32'(n == 0));
    check("afull",  32'(afull),  32'(n >= AF));
    check("aempty", 32'(aempty), 32'(n <= AE));
    check("wr_err", 32'(wr_err), 32'(exp_wr_err));
    check("rd_err", 32'(rd_err), 32'(exp_rd_err));
    check("rdata",  32'(rdata),  32'(exp_rd));
  endtask

  // Drive one cycle of requests, update the scoreboard, check after the edge.
  task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wr_en = wr;
    wdata = wd;
    rd_en = rd;
    rd_ok = rd && (exp_q.size() > 0);
    wr_ok = wr && ((exp_q.size() < DEPTH) || rd_ok);
    if (rd_ok) last_rd = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(wd);
    exp_wr_err = wr && !wr_ok;
    exp_rd_err = rd && !rd_ok;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_outputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_rd    = '0;
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;

    phase = "fill";
    for (int i = 1; i <= 16; i++) step(1'b1, WIDTH'(i), 1'b0);

    phase = "overflow";
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    phase = "drain";
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    phase = "underflow";
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    phase = "both_empty";
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    phase = "both_full";
    for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    step(1'b1, 8'hAB, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1);

    phase = "wrap";
    for (int i = 0; i < 40; i++) begin
      step(1'b1, WIDTH'(8'h20 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end

    phase = "async_reset_fill";
    for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    phase = "async_reset";
    model_reset();
    check_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    phase = "post_reset";
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      int unsigned wp;
      wp = (i < 200) ? 60 : 40;
      step($urandom_range(0, 99) < wp, WIDTH'($urandom), $urandom_range(0, 99) < (100 - wp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two >= 4.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full_o asserts when count_o >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty_o asserts when count_o <= AE_THRESH.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port wr_en_i, input, 1 bit: write request.
REQ-008 SHALL have port wdata_i, input, WIDTH bits: write data.
REQ-009 SHALL have port rd_en_i, input, 1 bit: read request.
REQ-010 SHALL have port rdata_o, output, WIDTH bits: read data.
REQ-011 SHALL have ports full_o and empty_o, each output, 1 bit: occupancy flags.
REQ-012 SHALL have ports almost_full_o and almost_empty_o, each output, 1 bit: threshold flags.
REQ-013 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-014 SHALL have ports wr_error_o and rd_error_o, each output, 1 bit: one-cycle pulses flagging a rejected request.

Function
REQ-015 SHALL accept a write when wr_en_i=1 and (full_o=0 or an accepted read occurs in the same cycle).
REQ-016 SHALL accept a read when rd_en_i=1 and empty_o=0; a read while empty is rejected even if a write occurs in the same cycle.
REQ-017 SHALL advance the write and read pointers modulo DEPTH on accepted operations, wrapping from DEPTH-1 to 0.
REQ-018 SHALL change count_o by +1 on write-only, -1 on read-only, and 0 on simultaneous accepted read and write, registered.
REQ-019 SHALL derive full_o (count_o==DEPTH), empty_o (count_o==0) and the almost flags combinationally from registered count_o.
REQ-020 SHALL leave all storage, pointers and count unchanged on a rejected request.
REQ-021 SHALL pulse wr_error_o high for exactly the cycle after a rejected write, and rd_error_o likewise after a rejected read.
REQ-022 SHALL, in standard mode, update rdata_o one cycle after an accepted read and hold it at all other times.

Reset
REQ-023 SHALL, while rst_ni=0, force pointers=0, count_o=0, rdata_o=0, wr_error_o=0, rd_error_o=0, giving empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
REQ-024 SHALL discard all contents on reset assertion mid-operation; storage array contents need not be cleared.
REQ-025 SHALL accept the first request on the first rising edge after rst_ni deasserts.

Configuration
REQ-026 SHALL, with macro SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through: rdata_o shows the head entry whenever empty_o=0, and an accepted read advances to the next entry on the following edge.
REQ-027 SHALL, without SYNC_FIFO_FWFT_EN, use the registered one-cycle read latency of REQ-022.
REQ-028 SHALL leave flags, count and error behaviour identical in both modes.

Structure
REQ-029 SHALL place the pointer-width constant function and the default thresholds in shared package sync_fifo_pkg.
REQ-030 SHALL implement storage as sub-module fifo_mem: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.

Verification
REQ-031 SHALL cover this scenario: reset, then 16 writes of 0x01..0x10 with DEPTH=16 -> full_o=1 and count_o=16 after the 16th edge, and almost_full_o=1 from count 14.
REQ-032 SHALL cover this scenario: a 17th write while full -> wr_error_o=1 for one cycle, and the contents and count_o=16 are unchanged.
REQ-033 SHALL cover this scenario: 16 reads after the fill -> data 0x01..0x10 in order at the mode-correct latency, then empty_o=1, and a further read gives rd_error_o=1.
REQ-034 SHALL cover this scenario: simultaneous read and write while full, and again while empty -> full case keeps count 16 with no error; empty case gives count 1 and rd_error_o=1.
REQ-035 SHALL cover this scenario: 40 write/read pairs to force pointer wrap -> data order preserved across the 15->0 transition.
REQ-036 SHALL cover this scenario: rst_ni pulled low with count_o=7 -> all outputs at reset values immediately (asynchronously), and the next write is read back first.
